// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Multi-cycle MIPS control sequencer. Steps each instruction
//             through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK over a
//             datapath with one ALU and one memory port. It drives every
//             datapath control line, waits on a memory ready handshake,
//             counts retired instructions and flags illegal opcodes and
//             memory timeouts.
//  Ports    : clk           - rising-edge clock
//             reset         - asynchronous, active-high reset
//             opcode[5:0]   - IR[31:26], valid from DECODE onward
//             zero          - ALU Zero flag (branch decision)
//             mem_ready     - memory completes the current access this cycle
//             mem_req/mem_read/mem_write/i_or_d - memory port controls
//             ir_write/pc_write/pc_src          - IR and PC update controls
//             alu_src_a/alu_src_b/alu_op        - ALU operand and op select
//             reg_dst/mem_to_reg/reg_write      - register file write controls
//             illegal_op    - one-cycle pulse on an undecoded opcode
//             mem_error     - one-cycle pulse on a memory timeout
//             instr_retired - completed-instruction count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 16,   // 0 = wait forever on mem_ready
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           alu_op,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 reg_write,
   output logic                 illegal_op,
   output logic                 mem_error,
   output logic [CNT_WIDTH-1:0] instr_retired
);

   // The wait counter only ever holds 0 .. MEM_TIMEOUT-1.
   localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT =
      c_WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
   localparam bit c_TMO_EN = (MEM_TIMEOUT > 0);

   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;
   localparam logic [5:0] c_OP_ORI   = 6'h0D;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_RTYPE_EX = 4'd3,
      S_RTYPE_WB = 4'd4,
      S_ITYPE_EX = 4'd5,
      S_ITYPE_WB = 4'd6,
      S_MEM_ADR  = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_MEM_WB   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [c_WAIT_W-1:0]    r_wait;
   logic [CNT_WIDTH-1:0]   r_retired;
   logic                   w_wait_state;
   logic                   w_timeout;
   logic                   w_retire;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);

   // Timeout fires on the MEM_TIMEOUT-th consecutive non-ready cycle; a
   // mem_ready arriving in that same cycle takes priority.
   assign w_timeout = c_TMO_EN && w_wait_state && !mem_ready &&
                      (r_wait == c_WAIT_LIMIT);

   assign instr_retired = r_retired;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // Wait counter and retired-instruction counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait    <= '0;
         r_retired <= '0;
      end else begin
         // Any state entry (including re-entering FETCH after a timeout)
         // restarts the wait count.
         if (w_timeout || (w_next != r_state)) begin
            r_wait <= '0;
         end else if (c_TMO_EN && w_wait_state && !mem_ready) begin
            r_wait <= r_wait + c_WAIT_W'(1);
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_WIDTH'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      mem_req    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      mem_error  = 1'b0;

      // Gating on reset keeps every strobe low from the instant reset rises,
      // independent of when the state register itself settles.
      if (!reset) begin
         case (r_state)
            S_IDLE: begin
               w_next = S_FETCH;
            end

            S_FETCH: begin
               mem_req   = 1'b1;
               mem_read  = 1'b1;
               alu_src_b = 2'b01;               // PC + 4
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  w_next   = S_DECODE;
               end else if (w_timeout) begin
                  mem_error = 1'b1;
                  w_next    = S_FETCH;
               end
            end

            S_DECODE: begin
               alu_src_b = 2'b11;               // branch target into ALUOut
               case (opcode)
                  c_OP_RTYPE:         w_next = S_RTYPE_EX;
                  c_OP_ADDI, c_OP_ORI: w_next = S_ITYPE_EX;
                  c_OP_LW, c_OP_SW:   w_next = S_MEM_ADR;
                  c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
                  c_OP_J:             w_next = S_JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     w_next     = S_FETCH;
                  end
               endcase
            end

            S_RTYPE_EX: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b111;
               w_next    = S_RTYPE_WB;
            end

            S_RTYPE_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               w_next    = S_FETCH;
               w_retire  = 1'b1;
            end

            S_ITYPE_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_op    = (opcode == c_OP_ORI) ? 3'b101 : 3'b100;
               w_next    = S_ITYPE_WB;
            end

            S_ITYPE_WB: begin
               reg_write = 1'b1;
               w_next    = S_FETCH;
               w_retire  = 1'b1;
            end

            S_MEM_ADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               w_next    = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (mem_ready) begin
                  w_next = S_MEM_WB;
               end else if (w_timeout) begin
                  mem_error = 1'b1;
                  w_next    = S_FETCH;
               end
            end

            S_MEM_WR: begin
               mem_req = 1'b1;
               i_or_d  = 1'b1;
               // The write strobe is only raised in the completing cycle so a
               // stalled or aborted store never commits.
               if (mem_ready) begin
                  mem_write = 1'b1;
                  w_next    = S_FETCH;
                  w_retire  = 1'b1;
               end else if (w_timeout) begin
                  mem_error = 1'b1;
                  w_next    = S_FETCH;
               end
            end

            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               w_next     = S_FETCH;
               w_retire   = 1'b1;
            end

            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b001;
               pc_src    = 2'b01;
               pc_write  = (opcode == c_OP_BNE) ? ~zero : zero;
               w_next    = S_FETCH;
               w_retire  = 1'b1;
            end

            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end

            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
